// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit_if : program-memory port plus fetch-to-decode valid/ready stage
// Revision 1.0
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_instruction;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instruction;
  logic [ADDR_W-1:0]  if_pc;

  modport master (
    output imem_address,
    input  imem_instruction,
    output if_valid,
    input  if_ready,
    output if_instruction,
    output if_pc
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    input  if_valid,
    output if_ready,
    input  if_instruction,
    input  if_pc
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit : PC owner, single-entry fetch register with branch/halt control
// Revision 1.0
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  instr_fetch_unit_if.master     bus,
  input  wire logic              branch_valid,
  input  wire logic [ADDR_W-1:0] branch_target,
  input  wire logic              halt,
  input  wire logic              resume,
  output logic                   halted
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  pc, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               load;
  logic               accept;

  assign load   = !valid_q || bus.if_ready;
  assign accept = valid_q && bus.if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pc      <= ADDR_W'(RESET_PC);
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Priority: branch > halt > resume > fetch; a held instruction may still drain.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (branch_valid) begin
      pc_d    = branch_target;
      valid_d = 1'b0;
    end else if (state == RUN) begin
      if (halt) begin
        state_d = HALT;
        if (accept) valid_d = 1'b0;
      end else if (load) begin
        instr_d = bus.imem_instruction;
        ipc_d   = pc;
        valid_d = 1'b1;
        pc_d    = pc + 1'b1;
      end
    end else begin
      if (accept) valid_d = 1'b0;
      if (!halt && resume) state_d = RUN;
    end
  end

  assign bus.imem_address   = pc;
  assign bus.if_valid       = valid_q;
  assign bus.if_instruction = instr_q;
  assign bus.if_pc          = ipc_q;
  assign halted             = (state == HALT);

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side master of the 8-bit-address / 16-bit-instruction program memory port.
- Owns the program counter and drives the memory address.
- The memory read is combinational, so the instruction returns in the same cycle.
- Registers the instruction and its PC into a single valid/ready output stage feeding decode; supports backpressure, branch redirect/flush and halt/resume.

Parameters:
ADDR_W, 8, program counter / memory address width
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_address  output  ADDR_W  address to instruction memory; combinationally equal to pc
imem_instruction  input  INSTR_W  memory read data for imem_address, valid same cycle
if_valid  output  1  fetch register holds an instruction for decode
if_ready  input  1  decode accepts when if_valid && if_ready at a clock edge
if_instruction  output  INSTR_W  registered instruction
if_pc  output  ADDR_W  address the registered instruction was fetched from
branch_valid  input  1  single-cycle redirect request
branch_target  input  ADDR_W  redirect address
halt  input  1  stop fetching
resume  input  1  leave halted state
halted  output  1  high while in HALT state

Behaviour:
- Reset (async, rst_n=0) sets pc=RESET_PC, if_valid=0, if_instruction=0, if_pc=0, halted=0, state=RUN. Asserting reset mid-operation discards any held instruction immediately.
- Internal pc register; imem_address=pc at all times, including while halted or stalled.
- load = !if_valid || if_ready.
- States: RUN, HALT. halted = (state==HALT).
- Priority per edge: branch > halt > resume > normal fetch.
- Branch (branch_valid=1, any state):
  - pc<=branch_target, if_valid<=0 (flush).
  - No fetch this cycle; state unchanged.
  - If if_valid && if_ready in the same cycle, that handshake still counts as accepted.
  - The first fetch from the target occurs on the next edge with load=1 in RUN.
- RUN, no branch, halt=1: state<=HALT, no fetch, pc holds. If if_valid && if_ready, if_valid<=0; otherwise the held instruction stays valid.
- RUN, no branch, halt=0, load=1:
  - if_instruction<=imem_instruction, if_pc<=pc, if_valid<=1.
  - pc<=pc+1 modulo 2^ADDR_W (0xFF wraps to 0x00).
- RUN, load=0 (stall): pc, if_instruction, if_pc, if_valid all hold.
- HALT:
  - No fetch; pc holds.
  - if_valid drops to 0 once the held instruction is accepted.
  - resume=1 (no branch) returns to RUN; fetch restarts on the following edge.
  - halt and resume both high: halt wins, stay HALT.
- Throughput: one instruction per cycle with if_ready tied high.
- Latency: instruction at address A is presented on if_instruction one edge after pc==A with load=1.
- First valid output appears at the first rising edge after rst_n deasserts.
- if_instruction and if_pc are stable whenever if_valid=1 and if_ready=0.
- All outputs are registered except imem_address, which is pc.

Test Plan:
- Reset release, memory[0..3]=0x1111,0x2222,0x3333,0x4444, if_ready=1 -> edges 1..4 give if_valid=1 with (if_pc,if_instruction)=(0,0x1111),(1,0x2222),(2,0x3333),(3,0x4444); imem_address 1,2,3,4.
- Backpressure: if_valid holds pc=2 instruction 0x3333, if_ready=0 for 3 cycles -> outputs and imem_address=3 frozen; if_ready=1 -> next edge if_pc=3.
- Branch: while if_pc=5, assert branch_valid with target 0x40 for one cycle -> next edge if_valid=0, imem_address=0x40; following edge if_pc=0x40 with memory[0x40] data.
- Wrap: branch to 0xFE, if_ready=1 -> if_pc sequence 0xFE,0xFF,0x00,0x01.
- Halt/resume: halt at if_pc=7, if_ready=0 -> halted=1, instruction 7 stays valid, imem_address=8. Set if_ready=1 -> if_valid=0. Pulse resume -> next valid if_pc=8. Also halt+resume together -> stays halted.
- Async reset mid-stream: drop rst_n between clock edges while if_valid=1 -> if_valid=0, imem_address=RESET_PC immediately, without waiting for a clock edge.
